// File: rtl/prio_enc_rr.sv
// prio_enc_rr
// N-input priority encoder with registered grant outputs and a valid/ready
// output handshake. Two selection modes: fixed priority (highest index wins)
// and round-robin (first request at or above a rotating pointer, wrapping).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        request lines, bit i = requester i
//   rr_en      1 = round-robin, 0 = fixed priority (sampled at evaluation edges)
//   out_ready  consumer accepts the pending grant
//   out_valid  grant pending
//   out_idx    encoded index of the granted requester
//   out_onehot one-hot grant, bit out_idx set (zero when no grant)
//   xfer_cnt   accepted-grant counter, wraps
module prio_enc_rr #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             rr_en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [N-1:0]     onehot_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             accept;
    logic             eval;
    int unsigned      pos;

    // out_valid is the state flop itself
    assign out_valid = (state == HOLD);

    always_comb begin
        accept = (state == HOLD) && out_ready;
        eval   = (state == IDLE) || out_ready;

        // The accept edge is also an evaluation edge, so the search below
        // must already see the advanced pointer for back-to-back grants.
        ptr_nxt = ptr;
        if (accept && rr_en) begin
            if (out_idx == IDX_W'(N - 1))
                ptr_nxt = '0;
            else
                ptr_nxt = out_idx + 1'b1;
        end

        win_idx   = '0;
        win_found = 1'b0;
        pos       = 0;
        if (rr_en) begin
            for (int unsigned k = 0; k < N; k++) begin
                pos = 32'(ptr_nxt) + k;
                if (pos >= N)
                    pos = pos - N;
                if (!win_found && req[pos]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(pos);
                end
            end
        end else begin
            // later (higher) indices overwrite earlier ones
            for (int unsigned i = 0; i < N; i++) begin
                if (req[i]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end

        state_nxt  = state;
        idx_nxt    = out_idx;
        onehot_nxt = out_onehot;
        cnt_nxt    = accept ? xfer_cnt + 1'b1 : xfer_cnt;

        if (eval) begin
            if (win_found) begin
                state_nxt  = HOLD;
                idx_nxt    = win_idx;
                onehot_nxt = {{(N-1){1'b0}}, 1'b1} << win_idx;
            end else begin
                state_nxt  = IDLE;
                idx_nxt    = '0;
                onehot_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            out_idx    <= '0;
            out_onehot <= '0;
            xfer_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            out_idx    <= idx_nxt;
            out_onehot <= onehot_nxt;
            xfer_cnt   <= cnt_nxt;
        end
    end

endmodule
